// File: rtl/rt_mem_pkg.sv
// Shared types for the ray-tracer memory path: node address/word widths and requester ids.
// Pure declarations. No latency and no flow control.
package rt_mem_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] node_addr_t;
    typedef logic [DATA_W-1:0] node_t;
    typedef logic [2:0]        req_id_t;

    function automatic req_id_t next_id(input req_id_t id, input int n);
        return (int'(id) + 1 >= n) ? req_id_t'(0) : req_id_t'(int'(id) + 1);
    endfunction
endpackage

// File: rtl/octant_rom_arbiter_rr.sv
// Combinational round-robin picker. The search starts at ptr and wraps N-1 -> 0.
// Zero latency. It has no state, and the caller holds the pointer.
module rr_arbiter
    import rt_mem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] eligible,
    input  req_id_t      ptr,
    output logic [N-1:0] grant,
    output req_id_t      grant_id,
    output logic         any_grant
);
    int sel;

    // Walk offsets from farthest to nearest so the closest eligible slot to ptr wins.
    always_comb begin
        sel       = 0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if ((i == int'(ptr) + k || i == int'(ptr) + k - N) && eligible[i]) begin
                    sel       = i;
                    any_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = any_grant && (i == sel);
        end
        grant_id = req_id_t'(sel);
    end
endmodule

// File: rtl/octant_rom_arbiter.sv
// Shares one single-port octant ROM among NUM_REQ requesters. A grant in cycle t gives rsp_valid in t+1+ROM_LAT.
// Backpressure: req_ready is the one-hot grant, and each requester has at most one read in flight.
module octant_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_ren,
    input  logic [DATA_W-1:0]         rom_dout,
    output logic                      busy,
    output logic [31:0]               conflict_cnt
);
    import rt_mem_pkg::*;

    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] eligible, grant, rsp_hit;
    req_id_t            rr_ptr_q, rr_ptr_d, grant_id;
    logic               any_grant;
    logic [ADDR_W-1:0]  grant_addr;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               rom_ren_q;
    logic [31:0]        conflict_q;
    logic [ROM_LAT:0]   tag_vld_q;
    req_id_t            tag_id_q [ROM_LAT+1];

    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_hit[i] = tag_vld_q[ROM_LAT] && (int'(tag_id_q[ROM_LAT]) == i);
        end
    end

    // A response exiting this cycle frees its requester for an immediate re-grant.
    assign eligible = reset ? '0 : (req_valid & (~pending_q | rsp_hit));

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign pending_d = (pending_q & ~rsp_hit) | grant;
    assign rr_ptr_d  = any_grant ? next_id(grant_id, NUM_REQ) : rr_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            rom_addr_q <= '0;
            rom_ren_q  <= 1'b0;
            conflict_q <= '0;
            tag_vld_q  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) tag_id_q[k] <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            rom_ren_q <= any_grant;
            if (any_grant) rom_addr_q <= grant_addr;
            tag_vld_q   <= {tag_vld_q[ROM_LAT-1:0], any_grant};
            tag_id_q[0] <= grant_id;
            for (int k = 1; k <= ROM_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
            if ($countones(eligible) >= 2 && conflict_q != 32'hFFFF_FFFF)
                conflict_q <= conflict_q + 32'd1;
        end
    end

    assign req_ready    = grant;
    assign rsp_valid    = rsp_hit;
    assign rsp_data     = rom_dout;
    assign rom_addr     = rom_addr_q;
    assign rom_ren      = rom_ren_q;
    assign busy         = |pending_q;
    assign conflict_cnt = conflict_q;
endmodule

// File: doc/octant_rom_arbiter.md
# octant_rom_arbiter

Shares one single-port octant ROM between NUM_REQ ray processors. Each ray processor issues node-fetch requests, and the arbiter grants them round-robin, one per cycle. It tracks each in-flight read with a tag pipeline matched to the ROM latency, then routes the returned node word back to the requester that issued it. The block sits between the ray processors' address/node ports and the octant ROM, so adding cores no longer needs extra ROM ports.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, node address width
- DATA_W, 32, node word width
- ROM_LAT, 1, cycles from rom_ren sampled high to rom_dout valid (1..4)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester fetch request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse when requester i's node word is on rsp_data
- rsp_data  out  DATA_W  broadcast node word
- rom_addr  out  ADDR_W  ROM address, registered
- rom_ren  out  1  ROM read enable, registered
- rom_dout  in  DATA_W  ROM read data
- busy  out  1  high while any request is outstanding
- conflict_cnt  out  32  count of cycles with two or more eligible requesters; saturates at 2^32-1

## Operation
- Each requester may have at most one outstanding request; pending[i] tracks this.
- Eligibility: eligible[i] = req_valid[i] & (~pending[i] | rsp_valid[i]). A requester can therefore be re-granted in the same cycle its response is delivered.
- Arbitration is combinational round-robin over eligible[]. The search starts at rr_ptr and wraps NUM_REQ-1 -> 0.
- Exactly one requester is granted per cycle when any is eligible. req_ready is zero when none are eligible.
- On a grant to requester g:
  - rr_ptr <= (g+1) mod NUM_REQ; rr_ptr is unchanged when there is no grant.
  - pending[g] is set.
  - rom_addr <= req_addr[g] and rom_ren <= 1. rom_ren <= 0 on cycles with no grant, and rom_addr holds its last value.
- Tag pipeline: ROM_LAT+1 stages, each holding {valid, id}. It is loaded with {1, g} on a grant, else {0, x}.
- At pipeline exit:
  - rsp_valid[id] = 1.
  - rsp_data = rom_dout, passed through combinationally.
  - pending[id] is cleared unless the same requester is re-granted in that cycle; re-grant takes priority and leaves pending set.
- Requesters must hold req_addr stable while req_valid=1 and not ready. Dropping req_valid before the grant is allowed, and no request is issued in that case.
- busy = |pending.
- conflict_cnt increments when popcount(eligible) >= 2.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data follows rom_dout but is don't-care.
  - rom_ren=0, rom_addr=0, busy=0, conflict_cnt=0.
  - rr_ptr=0, pending=0, all tag stages invalid.
- Latency: handshake in cycle t, rom_ren high in t+1, rsp_valid in t+1+ROM_LAT. For ROM_LAT=1 this is 2 cycles.
- Throughput: one ROM read per cycle across all requesters. A single requester achieves one request per 1+ROM_LAT cycles.
- Reset asserted mid-operation: all in-flight responses are dropped and no rsp_valid is produced for them. Requesters re-issue after reset.
- Reset deassertion: the first grant is possible in the first cycle reset is low.
- rsp_valid and req_ready for the same requester may both be high in one cycle.

## Structure
- Shared package rt_mem_pkg holds:
  - ADDR_W and DATA_W defaults (32/32).
  - typedef node_addr_t = logic [ADDR_W-1:0] and node_t = logic [DATA_W-1:0].
  - typedef req_id_t = logic [2:0].
- Sub-module rr_arbiter, parameter N:
  - Inputs: eligible and ptr.
  - Outputs: grant one-hot, grant_id, any_grant.
  - Purely combinational; rr_ptr is held in the parent.
- The tag pipeline, pending flags and counter live in octant_rom_arbiter.

## Test plan
- Single request, NUM_REQ=4, ROM_LAT=1: req0 at address 0x10 in cycle 0 -> req_ready[0] in cycle 0, rom_ren=1/rom_addr=0x10 in cycle 1, rsp_valid=4'b0001 with rsp_data=ROM[0x10] in cycle 2, busy high in cycles 1-2.
- All four requesting continuously from reset -> grant order 0,1,2,3,0,1... with one grant per cycle; conflict_cnt increments in every cycle with two or more eligible requesters; each rsp_valid arrives 2 cycles after its grant.
- Wrap and fairness: rr_ptr=3, requesters 0 and 3 request -> requester 3 is granted first, then 0 on the next cycle.
- Back-to-back: req1 held high -> grants in cycles 0, 2, 4 (re-grant coincides with rsp_valid[1]); pending[1] stays set throughout.
- Reset mid-flight: assert reset one cycle after grants to requesters 0 and 2 -> no rsp_valid pulses at all; all outputs return to reset values immediately; busy=0.
- ROM_LAT=3: grant in cycle 5 -> rsp_valid in cycle 9, with rsp_data matching the ROM model's delayed output.
